// File: rtl/tank_pkg.sv
// Shared tank motion types and default HID key codes.
// Used by both player instances of tank_motion.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    CRUISE
  } motion_state_t;

  localparam logic [7:0] KC_LEFT  = 8'h04;
  localparam logic [7:0] KC_RIGHT = 8'h07;
  localparam logic [7:0] KC_DOWN  = 8'h16;
  localparam logic [7:0] KC_UP    = 8'h1A;

endpackage

// File: rtl/tank_speed_ramp.sv
// Per-frame step generator; the ramp FSM exists only with
// TANK_MOTION_RAMP_EN defined, otherwise full speed at once.
module tank_speed_ramp
  import tank_pkg::*;
#(
  parameter int W           = 10,
  parameter int BASE_STEP   = 1,
  parameter int BOOST_STEP  = 3,
  parameter int RAMP_FRAMES = 4
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         go,
  input  logic         restart,
  input  logic         speed_upgrade,
  output logic [W-1:0] step_nxt
);

  logic [W-1:0] eff_max;

  assign eff_max = speed_upgrade ? W'(BOOST_STEP)
                                 : W'(BASE_STEP);

`ifdef TANK_MOTION_RAMP_EN
  localparam int CW = (RAMP_FRAMES > 1) ?
                      $clog2(RAMP_FRAMES) : 1;

  motion_state_t state, state_nxt;
  logic [W-1:0]  step_q, inc;
  logic [CW-1:0] cnt_q, cnt_nxt;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      step_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      step_q <= step_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    step_nxt  = '0;
    cnt_nxt   = '0;
    inc       = step_q;
    if (go) begin
      if (state == IDLE || restart) begin
        step_nxt = W'(1);
      end else if (state == RAMP) begin
        if (cnt_q == CW'(RAMP_FRAMES - 1))
          inc = step_q + W'(1);
        else
          cnt_nxt = cnt_q + CW'(1);
        step_nxt = (inc < eff_max) ? inc : eff_max;
      end else begin
        step_nxt = eff_max;
      end
      state_nxt = (step_nxt >= eff_max) ? CRUISE : RAMP;
      if (state_nxt == CRUISE)
        cnt_nxt = '0;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{frame_clk, Reset, restart};
  assign step_nxt  = go ? eff_max : '0;
`endif

endmodule

// File: rtl/tank_motion.sv
// Per-frame tank mover: key decode, clamp and position regs.
// Speed ramp enabled by defining TANK_MOTION_RAMP_EN.
module tank_motion
  import tank_pkg::*;
#(
  parameter int W           = 10,
  parameter int X_CENTER    = 160,
  parameter int Y_CENTER    = 240,
  parameter int X_MIN       = 1,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 1,
  parameter int Y_MAX       = 479,
  parameter int SIZE        = 8,
  parameter int BASE_STEP   = 1,
  parameter int BOOST_STEP  = 3,
  parameter int RAMP_FRAMES = 4,
  parameter logic [7:0] KEY_LEFT  = KC_LEFT,
  parameter logic [7:0] KEY_RIGHT = KC_RIGHT,
  parameter logic [7:0] KEY_DOWN  = KC_DOWN,
  parameter logic [7:0] KEY_UP    = KC_UP
) (
  input  logic         Reset,
  input  logic         frame_clk,
  input  logic [7:0]   keycode,
  input  logic         speed_upgrade,
  input  logic [3:0]   barrier_collision,
  input  logic         freeze,
  input  logic         respawn,
  output logic [W-1:0] BallX,
  output logic [W-1:0] BallY,
  output logic [W-1:0] BallS,
  output logic [1:0]   direction,
  output logic         moving
);

  localparam logic [W:0] X_LO = (W+1)'(X_MIN + SIZE);
  localparam logic [W:0] X_HI = (W+1)'(X_MAX - SIZE);
  localparam logic [W:0] Y_LO = (W+1)'(Y_MIN + SIZE);
  localparam logic [W:0] Y_HI = (W+1)'(Y_MAX - SIZE);

  dir_t         key_dir, dir_q;
  logic         key_ok, blk, horiz, dec;
  logic         at_lim, go, restart;
  logic [W:0]   pos_e, lo, hi, stp_e, up_t;
  logic [W-1:0] step_nxt, new_pos;

  always_comb begin
    key_ok  = 1'b1;
    key_dir = DIR_RIGHT;
    blk     = 1'b0;
    unique case (1'b1)
      keycode == KEY_RIGHT: begin
        key_dir = DIR_RIGHT;
        blk     = barrier_collision[0];
      end
      keycode == KEY_LEFT: begin
        key_dir = DIR_LEFT;
        blk     = barrier_collision[1];
      end
      keycode == KEY_DOWN: begin
        key_dir = DIR_DOWN;
        blk     = barrier_collision[2];
      end
      keycode == KEY_UP: begin
        key_dir = DIR_UP;
        blk     = barrier_collision[3];
      end
      default: key_ok = 1'b0;
    endcase
  end

  assign horiz = (key_dir == DIR_LEFT) ||
                 (key_dir == DIR_RIGHT);
  assign dec   = (key_dir == DIR_LEFT) ||
                 (key_dir == DIR_UP);
  assign pos_e = horiz ? {1'b0, BallX} : {1'b0, BallY};
  assign lo    = horiz ? X_LO : Y_LO;
  assign hi    = horiz ? X_HI : Y_HI;

  assign at_lim  = dec ? (pos_e <= lo) : (pos_e >= hi);
  assign go      = !respawn && !freeze && key_ok &&
                   !blk && !at_lim;
  assign restart = (key_dir != dir_q);

  tank_speed_ramp #(
    .W           (W),
    .BASE_STEP   (BASE_STEP),
    .BOOST_STEP  (BOOST_STEP),
    .RAMP_FRAMES (RAMP_FRAMES)
  ) u_ramp (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .go            (go),
    .restart       (restart),
    .speed_upgrade (speed_upgrade),
    .step_nxt      (step_nxt)
  );

  // Extra MSB keeps the sum and lo+step from wrapping.
  assign stp_e = {1'b0, step_nxt};
  assign up_t  = pos_e + stp_e;

  always_comb begin
    if (dec)
      new_pos = W'((pos_e >= lo + stp_e) ?
                   pos_e - stp_e : lo);
    else
      new_pos = W'((up_t > hi) ? hi : up_t);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      BallX  <= W'(X_CENTER);
      BallY  <= W'(Y_CENTER);
      dir_q  <= DIR_RIGHT;
      moving <= 1'b0;
    end else if (respawn) begin
      BallX  <= W'(X_CENTER);
      BallY  <= W'(Y_CENTER);
      dir_q  <= DIR_RIGHT;
      moving <= 1'b0;
    end else if (freeze) begin
      moving <= 1'b0;
    end else begin
      if (key_ok)
        dir_q <= key_dir;
      moving <= go;
      if (go && horiz)
        BallX <= new_pos;
      if (go && !horiz)
        BallY <= new_pos;
    end
  end

  assign direction = dir_q;
  assign BallS     = W'(SIZE);

endmodule
